// File: rtl/fp_norm_round_pack.sv
// fp_norm_round_pack: normalizes a raw significand sum and rounds it to nearest-even.
// It then packs the result as an IEEE-754 single. The datapath is a 2-stage valid/ready pipeline.
// Subnormals are not produced; underflow flushes to a signed zero.
module fp_norm_round_pack #(
    parameter int unsigned SIG_WIDTH = 23,
    parameter int unsigned EXP_WIDTH = 8,
    parameter int unsigned BIAS      = 127
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_sign,
    input  logic [EXP_WIDTH+1:0]           in_exp,
    input  logic [2*SIG_WIDTH+2:0]         in_sum,
    input  logic [5:0]                     in_norm_amt,
    input  logic                           in_right_shift,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [EXP_WIDTH+SIG_WIDTH:0]   out_result,
    output logic                           out_overflow,
    output logic                           out_underflow,
    output logic                           out_inexact,
    output logic                           out_zero
);

    localparam int unsigned SUM_W = 2 * SIG_WIDTH + 3;          // raw sum incl. carry bit
    localparam int unsigned M_W   = SUM_W - 1;                  // normalized significand, 1.0 at MSB
    localparam int unsigned F_W   = M_W - 1;                    // bits below the hidden one
    localparam int unsigned IE_W  = EXP_WIDTH + 2;              // incoming exponent width
    localparam int unsigned E_W   = EXP_WIDTH + 3;              // internal signed exponent width
    localparam int unsigned RES_W = 1 + EXP_WIDTH + SIG_WIDTH;
    localparam int unsigned G_IDX = F_W - 1 - SIG_WIDTH;        // guard bit position

    // Exponent code reserved for infinity, and the smallest normal exponent code.
    localparam logic signed [E_W-1:0] EXP_INF = E_W'(2 * BIAS + 1);
    localparam logic signed [E_W-1:0] EXP_MIN = E_W'(1);

    // Stage 1 registers
    logic                   s1_valid_q;
    logic                   s1_sign_q,   s1_sign_d;
    logic signed [E_W-1:0]  s1_exp_q,    s1_exp_d;
    logic [F_W-1:0]         s1_mant_q,   s1_mant_d;
    logic                   s1_sticky_q, s1_sticky_d;
    logic                   s1_zero_q,   s1_zero_d;

    // Output registers
    logic                   out_valid_q;
    logic [RES_W-1:0]       out_result_q,    out_result_d;
    logic                   out_overflow_q,  out_overflow_d;
    logic                   out_underflow_q, out_underflow_d;
    logic                   out_inexact_q,   out_inexact_d;
    logic                   out_zero_q,      out_zero_d;

    // Round stage intermediates
    logic signed [E_W-1:0]  in_exp_ext;
    logic [SIG_WIDTH-1:0]   frac;
    logic                   guard;
    logic                   sticky;
    logic                   round_up;
    logic [SIG_WIDTH:0]     frac_rnd;
    logic signed [E_W-1:0]  exp_rnd;

    logic                   s2_advance;

    // Output stage moves when empty or drained; input stage moves when empty or stage 2 moves.
    assign s2_advance = !out_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s2_advance;

    assign in_exp_ext = {{(E_W - IE_W){in_exp[IE_W-1]}}, in_exp};

    // Normalize: either undo the carry with a right shift or left-shift the leading one to the top.
    always_comb begin
        s1_sign_d   = in_sign;
        s1_zero_d   = (in_sum == '0);
        s1_mant_d   = '0;
        s1_exp_d    = in_exp_ext;
        s1_sticky_d = 1'b0;
        if (in_right_shift) begin
            s1_mant_d   = in_sum[M_W-1:1];
            s1_exp_d    = in_exp_ext + E_W'(1);
            s1_sticky_d = in_sum[0];
        end else begin
            s1_mant_d   = F_W'(in_sum[M_W-1:0] << in_norm_amt);
            s1_exp_d    = in_exp_ext - E_W'(in_norm_amt);
        end
    end

    // Round to nearest-even, then classify against the post-rounding exponent and pack.
    always_comb begin
        frac     = s1_mant_q[F_W-1 -: SIG_WIDTH];
        guard    = s1_mant_q[G_IDX];
        sticky   = (|s1_mant_q[G_IDX-1:0]) | s1_sticky_q;
        round_up = guard & (sticky | frac[0]);
        frac_rnd = {1'b0, frac} + (SIG_WIDTH + 1)'(round_up);
        exp_rnd  = s1_exp_q + E_W'(frac_rnd[SIG_WIDTH]);

        out_result_d    = {s1_sign_q, exp_rnd[EXP_WIDTH-1:0], frac_rnd[SIG_WIDTH-1:0]};
        out_overflow_d  = 1'b0;
        out_underflow_d = 1'b0;
        out_inexact_d   = guard | sticky;
        out_zero_d      = 1'b0;

        if (s1_zero_q) begin
            out_result_d  = {s1_sign_q, (RES_W - 1)'(0)};
            out_inexact_d = 1'b0;
            out_zero_d    = 1'b1;
        end else if (exp_rnd >= EXP_INF) begin
            out_result_d   = {s1_sign_q, {EXP_WIDTH{1'b1}}, SIG_WIDTH'(0)};
            out_overflow_d = 1'b1;
            out_inexact_d  = 1'b1;
        end else if (exp_rnd < EXP_MIN) begin
            out_result_d    = {s1_sign_q, (RES_W - 1)'(0)};
            out_underflow_d = 1'b1;
            out_inexact_d   = 1'b1;
            out_zero_d      = 1'b1;
        end
    end

    // Pipeline registers; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q      <= 1'b0;
            s1_sign_q       <= 1'b0;
            s1_exp_q        <= '0;
            s1_mant_q       <= '0;
            s1_sticky_q     <= 1'b0;
            s1_zero_q       <= 1'b0;
            out_valid_q     <= 1'b0;
            out_result_q    <= '0;
            out_overflow_q  <= 1'b0;
            out_underflow_q <= 1'b0;
            out_inexact_q   <= 1'b0;
            out_zero_q      <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_sign_q   <= s1_sign_d;
                    s1_exp_q    <= s1_exp_d;
                    s1_mant_q   <= s1_mant_d;
                    s1_sticky_q <= s1_sticky_d;
                    s1_zero_q   <= s1_zero_d;
                end
            end
            if (s2_advance) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_result_q    <= out_result_d;
                    out_overflow_q  <= out_overflow_d;
                    out_underflow_q <= out_underflow_d;
                    out_inexact_q   <= out_inexact_d;
                    out_zero_q      <= out_zero_d;
                end
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign out_overflow  = out_overflow_q;
    assign out_underflow = out_underflow_q;
    assign out_inexact   = out_inexact_q;
    assign out_zero      = out_zero_q;

endmodule
